// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch and data port share one
// single-cycle memory. Each access takes 3 cycles (grant, access, response).
// Default build: fixed priority (data wins) with an ifetch starvation counter.
// Define MEM_ARB_RR_EN for round-robin arbitration instead.
module mem_arbiter #(
  parameter int unsigned IF_STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_func3,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  // memory port
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_func3,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned CNT_MAX   = 15;
  localparam logic [2:0]  FUNC3_WORD = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic             pick_if;
  logic             grant_if;
  logic             grant_d;
  logic             lat_is_d;
  logic             lat_we;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;
  logic [2:0]       lat_func3;

`ifdef MEM_ARB_RR_EN
  logic             last_if;
`else
  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;
`endif

  // Arbitration: choose ifetch or data when both request
`ifdef MEM_ARB_RR_EN
  always_comb begin
    pick_if = if_req & (~d_req | ~last_if);
  end
`else
  always_comb begin
    starve_hit = (starve_cnt >= CNT_W'(IF_STARVE_MAX));
    pick_if    = if_req & (~d_req | starve_hit);
  end
`endif

  // Grants only open in IDLE and never while reset is asserted
  always_comb begin
    grant_if = rst_n & (state == IDLE) & pick_if;
    grant_d  = rst_n & (state == IDLE) & d_req & ~pick_if;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (if_req || d_req) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: grants, memory strobes in ACCESS, response pulse in RESP
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_func3 = 3'd0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if_gnt = grant_if;
          d_gnt  = grant_d;
        end
        ACCESS: begin
          mem_read  = ~lat_we;
          mem_write = lat_we;
          mem_addr  = lat_addr;
          mem_wdata = lat_wdata;
          mem_func3 = lat_func3;
        end
        RESP: begin
          if_rvalid = ~lat_is_d;
          d_rvalid  = lat_is_d;
        end
        default: ;
      endcase
    end
  end

  // Latch the winning request on the grant edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_is_d  <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_func3 <= 3'd0;
    end else if (grant_d) begin
      lat_is_d  <= 1'b1;
      lat_we    <= d_we;
      lat_addr  <= d_addr;
      lat_wdata <= d_wdata;
      lat_func3 <= d_func3;
    end else if (grant_if) begin
      lat_is_d  <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= if_addr;
      lat_wdata <= 32'd0;
      lat_func3 <= FUNC3_WORD;
    end
  end

  // Capture read data at the end of ACCESS; stores return zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_rdata <= 32'd0;
      d_rdata  <= 32'd0;
    end else if (state == ACCESS) begin
      if (lat_is_d) d_rdata  <= lat_we ? 32'd0 : mem_rdata;
      else          if_rdata <= mem_rdata;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Remember which requester was served last
  always_ff @(posedge clk) begin
    if (!rst_n)        last_if <= 1'b1;
    else if (grant_if) last_if <= 1'b1;
    else if (grant_d)  last_if <= 1'b0;
  end
`else
  // Count consecutive ifetch losses; cleared on ifetch grant or idle ifetch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!if_req || grant_if)
        starve_cnt <= '0;
      else if (grant_d && (starve_cnt < CNT_W'(CNT_MAX)))
        starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, grant-order and
// reset-abort sequences, then randomized traffic against a transaction model.
module tb_mem_arbiter;

  localparam int unsigned STARVE = 2;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_func3;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_func3;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.IF_STARVE_MAX(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_func3(d_func3), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word-addressed memory model, combinational read, write on clock edge
  logic [31:0] mem [0:255];
  logic        mem_init = 1'b0;
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      mem[4]   <= 32'hDEADBEEF;
      mem_init <= 1'b1;
    end else if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  logic [31:0] ref_mem [0:255];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0; d_func3 = 3'd0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_mem_idle(input string tag);
    chk({tag, ".mem_read"},  32'(mem_read),  32'd0);
    chk({tag, ".mem_write"}, 32'(mem_write), 32'd0);
    chk({tag, ".mem_addr"},  mem_addr,       32'd0);
    chk({tag, ".mem_wdata"}, mem_wdata,      32'd0);
    chk({tag, ".mem_func3"}, 32'(mem_func3), 32'd0);
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  func3;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  // Single transaction through all three phases
  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    logic [2:0] ef3;
    tag = $sformatf("vec%0d", idx);
    ef3 = v.is_d ? v.func3 : 3'b010;
    @(posedge clk); #1;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_func3 = v.func3;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    @(negedge clk);
    chk({tag, ".if_gnt"}, 32'(if_gnt), 32'(!v.is_d));
    chk({tag, ".d_gnt"},  32'(d_gnt),  32'(v.is_d));
    chk_mem_idle({tag, ".grant"});
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk({tag, ".mem_read"},  32'(mem_read),  32'(!v.we));
    chk({tag, ".mem_write"}, 32'(mem_write), 32'(v.we));
    chk({tag, ".mem_addr"},  mem_addr,       v.addr);
    chk({tag, ".mem_wdata"}, mem_wdata,      v.is_d ? v.wdata : 32'd0);
    chk({tag, ".mem_func3"}, 32'(mem_func3), 32'(ef3));
    chk({tag, ".gnt_in_access"}, 32'({if_gnt, d_gnt}), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, ".if_rvalid"}, 32'(if_rvalid), 32'(!v.is_d));
    chk({tag, ".d_rvalid"},  32'(d_rvalid),  32'(v.is_d));
    chk({tag, ".rdata"}, v.is_d ? d_rdata : if_rdata, v.exp_rdata);
    chk_mem_idle({tag, ".resp"});
  endtask

  // Both requesters asserting continuously; record the first six winners
  task automatic grant_order();
    logic exp_order [6];
    logic got_order [6];
    int   n;
    int   budget;
`ifdef MEM_ARB_RR_EN
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
`endif
    n = 0;
    budget = 40;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_func3 = 3'b010;
    while (n < 6 && budget > 0) begin
      @(negedge clk);
      if (if_gnt && d_gnt) chk("order.both_gnt", 32'd1, 32'd0);
      if (d_gnt)       begin got_order[n] = 1'b1; n++; end
      else if (if_gnt) begin got_order[n] = 1'b0; n++; end
      budget--;
      @(posedge clk); #1;
    end
    if (n < 6) chk("order.timeout_grants", 32'(n), 32'd6);
    for (int i = 0; i < n; i++)
      chk($sformatf("order.grant%0d_is_d", i), 32'(got_order[i]), 32'(exp_order[i]));
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Store granted, then reset asserted during its ACCESS cycle
  task automatic reset_abort();
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hA5A5A5A5; d_func3 = 3'b010;
    @(negedge clk);
    chk("abort.d_gnt", 32'(d_gnt), 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort.mem_write", 32'(mem_write), 32'd0);
    chk("abort.mem_read",  32'(mem_read),  32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_mem_idle("abort.after");
    chk("abort.d_rvalid",  32'(d_rvalid),  32'd0);
    chk("abort.if_rvalid", 32'(if_rvalid), 32'd0);
    chk("abort.d_rdata",   d_rdata,        32'd0);
    chk("abort.if_rdata",  if_rdata,       32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort.late_d_rvalid", 32'(d_rvalid), 32'd0);
      @(posedge clk); #1;
    end
    chk("abort.mem_word16", mem[16], 32'd0);
  endtask

  // Randomized traffic against a transaction-level model
  task automatic run_random(input int ncyc);
    int          free_at, acc_t, rsp_t, losses;
    bit          last_if;
    bit          if_pend, d_pend, eg_if, eg_d;
    logic [31:0] held_if, held_d;
    logic        acc_we, rsp_is_d;
    logic [31:0] acc_addr, acc_wdata, rsp_data;
    logic [2:0]  acc_f3;
    logic [31:0] ia, da, dw;
    logic        dwe;
    logic [2:0]  df;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    free_at = 0; acc_t = -1; rsp_t = -1; losses = 0; last_if = 1'b1;
    if_pend = 1'b0; d_pend = 1'b0; held_if = 32'd0; held_d = 32'd0;
    acc_we = 1'b0; acc_addr = 32'd0; acc_wdata = 32'd0; acc_f3 = 3'd0;
    rsp_is_d = 1'b0; rsp_data = 32'd0;
    ia = 32'd0; da = 32'd0; dw = 32'd0; dwe = 1'b0; df = 3'd0;
    for (int t = 0; t < ncyc; t++) begin
      @(posedge clk); #1;
      if (!if_pend && $urandom_range(0, 3) != 0) begin
        if_pend = 1'b1;
        ia = 32'($urandom_range(0, 63)) << 2;
      end
      if (!d_pend && $urandom_range(0, 3) != 0) begin
        d_pend = 1'b1;
        da  = 32'($urandom_range(0, 63)) << 2;
        dw  = $urandom;
        dwe = 1'($urandom_range(0, 1));
        df  = 3'($urandom_range(0, 7));
      end
      if_req = if_pend; if_addr = ia;
      d_req = d_pend; d_addr = da; d_wdata = dw; d_we = dwe; d_func3 = df;
      @(negedge clk);
      // memory port this cycle
      if (t == acc_t) begin
        chk("rnd.mem_read",  32'(mem_read),  32'(!acc_we));
        chk("rnd.mem_write", 32'(mem_write), 32'(acc_we));
        chk("rnd.mem_addr",  mem_addr,       acc_addr);
        chk("rnd.mem_wdata", mem_wdata,      acc_wdata);
        chk("rnd.mem_func3", 32'(mem_func3), 32'(acc_f3));
      end else begin
        chk_mem_idle("rnd.idle");
      end
      // response this cycle
      if (t == rsp_t) begin
        if (rsp_is_d) held_d = rsp_data;
        else          held_if = rsp_data;
      end
      chk("rnd.if_rvalid", 32'(if_rvalid), 32'(t == rsp_t && !rsp_is_d));
      chk("rnd.d_rvalid",  32'(d_rvalid),  32'(t == rsp_t && rsp_is_d));
      chk("rnd.if_rdata",  if_rdata, held_if);
      chk("rnd.d_rdata",   d_rdata,  held_d);
      // arbitration: only once the previous transaction has fully retired
      eg_if = 1'b0; eg_d = 1'b0;
      if (t >= free_at) begin
        if (if_pend && d_pend) begin
`ifdef MEM_ARB_RR_EN
          eg_if = !last_if;
`else
          eg_if = (losses >= int'(STARVE));
`endif
          eg_d = !eg_if;
        end else begin
          eg_if = if_pend;
          eg_d  = d_pend;
        end
        if (!if_pend || eg_if) losses = 0;
        else                   losses++;
      end
      chk("rnd.if_gnt", 32'(if_gnt), 32'(eg_if));
      chk("rnd.d_gnt",  32'(d_gnt),  32'(eg_d));
      if (eg_if || eg_d) begin
        acc_t = t + 1; rsp_t = t + 2; free_at = t + 3;
        last_if = eg_if;
        rsp_is_d = eg_d;
        if (eg_d) begin
          acc_we = dwe; acc_addr = da; acc_wdata = dw; acc_f3 = df;
          if (dwe) begin
            ref_mem[da[9:2]] = dw;
            rsp_data = 32'd0;
          end else begin
            rsp_data = ref_mem[da[9:2]];
          end
          d_pend = 1'b0;
        end else begin
          acc_we = 1'b0; acc_addr = ia; acc_wdata = 32'd0; acc_f3 = 3'b010;
          rsp_data = ref_mem[ia[9:2]];
          if_pend = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h20, 32'h12345678, 3'b010, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h20, 32'h0,        3'b010, 32'h12345678};
    vecs[3] = '{1'b1, 1'b0, 32'h10, 32'h0,        3'b111, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b0, 32'h20, 32'h0,        3'b010, 32'h12345678};
    vecs[5] = '{1'b1, 1'b1, 32'h24, 32'hCAFEF00D, 3'b000, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 32'h24, 32'h0,        3'b010, 32'hCAFEF00D};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.if_gnt",    32'(if_gnt),    32'd0);
    chk("reset.d_gnt",     32'(d_gnt),     32'd0);
    chk("reset.if_rvalid", 32'(if_rvalid), 32'd0);
    chk("reset.d_rvalid",  32'(d_rvalid),  32'd0);
    chk("reset.if_rdata",  if_rdata,       32'd0);
    chk("reset.d_rdata",   d_rdata,        32'd0);
    chk_mem_idle("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);
    chk("vec.mem_word8", mem[8], 32'h12345678);

    do_reset();
    grant_order();
    reset_abort();
    do_reset();
    run_random(600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
